// File: rtl/seq_divider_pkg.sv
// Shared arithmetic-unit constants: FSM state encoding, counter sizing and the
// error quotient used by the sequential divider and the shift-add multiplier.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Widest legal operand is 16 bits; users slice down to their own N.
  localparam logic [15:0] ERR_QUOT = 16'hFFFF;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/operand/result bundle between the arithmetic-unit controller and the
// sequential divider.
interface seq_divider_if #(parameter int N = 8);

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div0;
  logic           ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div0, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div0, ovf
  );

endinterface

// File: rtl/seq_divider_sub_bx.sv
// W-bit subtractor for the divider's trial subtraction: a (W bits) minus a
// zero-extended (W-1)-bit b, returning the low W-1 bits and the sign bit.
module sub_bx #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-2:0] b,
  output logic [W-2:0] diff,
  output logic         borrow
);

  // a is always below 2*b in the divider, so the sign bit is exactly the borrow.
  assign {borrow, diff} = a - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock, with divide-by-zero and quotient-overflow detection.
module seq_divider
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_width(N);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  b_q, b_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          div0_q, div0_d;
  logic          ovf_q, ovf_d;

  logic [N:0]    a_wide;
  logic [N-1:0]  t_diff;
  logic          t_borrow;

  // {C, A_shifted}: A shifted left with the top bit of Q entering at the bottom.
  assign a_wide = {a_q, q_q[N-1]};

  sub_bx #(.W(N + 1)) u_sub (
    .a      (a_wide),
    .b      (b_q),
    .diff   (t_diff),
    .borrow (t_borrow)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    b_d     = b_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          div0_d = 1'b0;
          ovf_d  = 1'b0;
          if (bus.divisor == '0) begin
            div0_d  = 1'b1;
            quot_d  = ERR_QUOT[N-1:0];
            rem_d   = '0;
            state_d = ST_DONE;
          end else if (bus.dividend[2*N-1:N] >= bus.divisor) begin
            ovf_d   = 1'b1;
            quot_d  = ERR_QUOT[N-1:0];
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            a_d     = bus.dividend[2*N-1:N];
            q_d     = bus.dividend[N-1:0];
            b_d     = bus.divisor;
            count_d = CW'(N);
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        a_d     = t_borrow ? a_wide[N-1:0] : t_diff;
        q_d     = {q_q[N-2:0], ~t_borrow};
        count_d = count_q - 1'b1;
        if (count_d == '0) begin
          quot_d  = q_d;
          rem_d   = a_d;
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      b_q     <= b_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.div0      = div0_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases plus random operands, checked
// against plain integer division with the divider's error rules.
module tb_seq_divider;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Integer-division reference: error results are all-ones quotient, zero remainder.
  function automatic void refModel(input int unsigned dvd, input int unsigned dvs,
                                   output logic [N-1:0] q, output logic [N-1:0] r,
                                   output logic d0, output logic ov);
    d0 = 1'b0;
    ov = 1'b0;
    q  = '1;
    r  = '0;
    if (dvs == 0) d0 = 1'b1;
    else if (dvd / dvs >= (1 << N)) ov = 1'b1;
    else begin
      q = N'(dvd / dvs);
      r = N'(dvd % dvs);
    end
  endfunction

  task automatic applyStimulus(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    logic [N-1:0] eq, er;
    logic         ed0, eov;
    int           lat, busy_cnt, exp_lat;
    refModel(dvd, dvs, eq, er, ed0, eov);
    exp_lat  = (ed0 || eov) ? 1 : N + 1;
    lat      = 0;
    busy_cnt = 0;
    applyStimulus(dvd, dvs);
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
    end while (!bus.done && lat < 40);
    checkOutput({name, ".latency"}, lat, exp_lat);
    checkOutput({name, ".quotient"}, bus.quotient, eq);
    checkOutput({name, ".remainder"}, bus.remainder, er);
    checkOutput({name, ".div0"}, bus.div0, ed0);
    checkOutput({name, ".ovf"}, bus.ovf, eov);
    checkOutput({name, ".busy_cycles"}, busy_cnt, exp_lat);
    @(negedge clk);
    checkOutput({name, ".done_low_after"}, bus.done, 1'b0);
    checkOutput({name, ".busy_low_after"}, bus.busy, 1'b0);
    checkOutput({name, ".quotient_held"}, bus.quotient, eq);
  endtask

  initial begin
    int dones;
    logic [N-1:0]   rdvs;
    logic [2*N-1:0] rdvd;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #1;
    checkOutput("reset.quotient", bus.quotient, 0);
    checkOutput("reset.remainder", bus.remainder, 0);
    checkOutput("reset.busy", bus.busy, 0);
    checkOutput("reset.done", bus.done, 0);
    checkOutput("reset.div0", bus.div0, 0);
    checkOutput("reset.ovf", bus.ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp("nominal", 16'h03E8, 8'd7);
    runOp("max_legal", 16'hFEFF, 8'hFF);
    runOp("overflow", 16'h0800, 8'h08);
    runOp("div_zero", 16'h1234, 8'h00);
    runOp("after_div0", 16'd50, 8'd7);
    runOp("hi_equal_boundary", 16'h07FF, 8'h08);
    runOp("zero_dividend", 16'h0000, 8'd5);

    // Second start and new operands mid-run must not disturb the first division.
    applyStimulus(16'd100, 8'd9);
    dones = 0;
    for (int cyc = 1; cyc <= N + 4; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (cyc == 3) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd5000;
        bus.divisor  = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
    end
    checkOutput("busy_start.done_count", dones, 1);
    checkOutput("busy_start.quotient", bus.quotient, 11);
    checkOutput("busy_start.remainder", bus.remainder, 1);

    // Reset partway through RUN clears everything at once and never pulses done.
    applyStimulus(16'h03E8, 8'd7);
    repeat (4) @(negedge clk);
    checkOutput("mid_reset.busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset.quotient", bus.quotient, 0);
    checkOutput("mid_reset.remainder", bus.remainder, 0);
    checkOutput("mid_reset.busy", bus.busy, 0);
    checkOutput("mid_reset.done", bus.done, 0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    repeat (N + 2) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checkOutput("mid_reset.no_done", dones, 0);
    runOp("post_reset", 16'd255, 8'd16);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rdvd = 16'($urandom);
        rdvs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end else begin
        rdvs = 8'($urandom_range(1, 255));
        rdvd = 16'($urandom_range(0, int'(rdvs) * 256 - 1));
      end
      runOp($sformatf("random%0d", i), rdvd, rdvs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
